slv_req_arb: RTL and testbench

Round-robin arbiter that shares one register-slave request port among NUM_REQ upstream requesters. It sits upstream of the slave request/ack FSM. It latches one requester's command, issues a single-cycle request downstream, and waits for the ack or a timeout. It then routes ack, read data and error back to the granted requester, one transaction at a time.

---
 rtl/slv_arb_pkg.sv | 18 +
 rtl/slv_rr_arb.sv | 32 +++
 rtl/slv_req_arb.sv | 185 ++++++++++++++++++
 tb/tb_slv_req_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slv_arb_pkg.sv
// Shared types and reset constants for the register-slave request arbiter.
package slv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam arb_state_t RST_STATE = ST_IDLE;

    // last_grant resets to the top index so requester 0 is searched first
    function automatic int last_grant_rst(input int num_req);
        return num_req - 1;
    endfunction

endpackage

// File: rtl/slv_rr_arb.sv
// Combinational rotate-priority pick: first set request strictly after last_grant, with wrap.
module slv_rr_arb
    import slv_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int idx;
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = int'(last_grant) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[IDX_W'(idx)]) begin
                grant   = IDX_W'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slv_req_arb.sv
// Round-robin arbiter sharing one register-slave request port among NUM_REQ requesters,
// one latched transaction at a time with an optional WAIT timeout.
module slv_req_arb
    import slv_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           soft_rst,
    input  logic [NUM_REQ-1:0]             up_req_vld,
    input  logic [NUM_REQ-1:0]             up_wr_en,
    input  logic [NUM_REQ-1:0]             up_rd_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  up_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  up_wr_data,
    output logic [NUM_REQ-1:0]             up_ack_vld,
    output logic [DATA_WIDTH-1:0]          up_rd_data,
    output logic                           up_err,
    output logic                           dn_req_vld,
    output logic                           dn_wr_en,
    output logic                           dn_rd_en,
    output logic [ADDR_WIDTH-1:0]          dn_addr,
    output logic [DATA_WIDTH-1:0]          dn_wr_data,
    input  logic                           dn_ack_vld,
    input  logic [DATA_WIDTH-1:0]          dn_rd_data,
    input  logic                           dn_err,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(last_grant_rst(NUM_REQ));
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    arb_state_t            state_reg, state_next;
    logic [IDX_W-1:0]      last_grant_reg, last_grant_next;
    logic [IDX_W-1:0]      grant_reg, grant_next;
    logic                  wr_reg, wr_next;
    logic                  rd_reg, rd_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  err_reg, err_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;

    logic [IDX_W-1:0]      pick;
    logic                  any_req;
    logic                  dn_active;
    logic                  resp;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]   = up_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi]  = up_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign up_ack_vld[gi] = resp && (grant_reg == IDX_W'(gi));
        end
    endgenerate

    slv_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req        (up_req_vld),
        .last_grant (last_grant_reg),
        .grant      (pick),
        .any_req    (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= RST_STATE;
            last_grant_reg <= LAST_RST;
            grant_reg      <= '0;
            wr_reg         <= 1'b0;
            rd_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            wr_reg         <= wr_next;
            rd_reg         <= rd_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
            cnt_reg        <= cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        wr_next         = wr_reg;
        rd_next         = rd_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
        cnt_next        = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    grant_next = pick;
                    wr_next    = up_wr_en[pick];
                    rd_next    = up_rd_en[pick] & ~up_wr_en[pick];
                    addr_next  = addr_arr[pick];
                    wdata_next = wdata_arr[pick];
                    rdata_next = '0;
                    // A request with no command is answered locally with an error.
                    if (up_wr_en[pick] || up_rd_en[pick]) begin
                        err_next   = 1'b0;
                        state_next = ST_ISSUE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (dn_ack_vld) begin
                    rdata_next = wr_reg ? '0 : dn_rd_data;
                    err_next   = dn_err;
                    state_next = ST_RESP;
                end else if ((TIMEOUT_CYC != 0) && (cnt_reg == CNT_LAST)) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_grant_next = grant_reg;
                state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort overrides whatever the FSM decided this cycle.
        if (soft_rst) begin
            state_next      = RST_STATE;
            last_grant_next = LAST_RST;
            grant_next      = '0;
            wr_next         = 1'b0;
            rd_next         = 1'b0;
            addr_next       = '0;
            wdata_next      = '0;
            rdata_next      = '0;
            err_next        = 1'b0;
            cnt_next        = '0;
        end
    end

    assign resp       = (state_reg == ST_RESP);
    assign dn_active  = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign busy       = (state_reg != ST_IDLE);
    assign dn_req_vld = (state_reg == ST_ISSUE);
    assign dn_wr_en   = dn_active & wr_reg;
    assign dn_rd_en   = dn_active & rd_reg;
    assign dn_addr    = dn_active ? addr_reg : '0;
    assign dn_wr_data = dn_active ? wdata_reg : '0;
    assign up_rd_data = resp ? rdata_reg : '0;
    assign up_err     = resp & err_reg;
    assign grant_id   = grant_reg;

endmodule

// File: tb/tb_slv_req_arb.sv
// Directed bench for slv_req_arb: 4 requesters, 8-cycle timeout, one line per transaction.
module tb_slv_req_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic         soft_rst;
    logic [3:0]   up_req_vld;
    logic [3:0]   up_wr_en;
    logic [3:0]   up_rd_en;
    logic [127:0] up_addr;
    logic [127:0] up_wr_data;
    logic [3:0]   up_ack_vld;
    logic [31:0]  up_rd_data;
    logic         up_err;
    logic         dn_req_vld;
    logic         dn_wr_en;
    logic         dn_rd_en;
    logic [31:0]  dn_addr;
    logic [31:0]  dn_wr_data;
    logic         dn_ack_vld;
    logic [31:0]  dn_rd_data;
    logic         dn_err;
    logic [1:0]   grant_id;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    slv_req_arb #(
        .NUM_REQ     (4),
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_rst   (soft_rst),
        .up_req_vld (up_req_vld),
        .up_wr_en   (up_wr_en),
        .up_rd_en   (up_rd_en),
        .up_addr    (up_addr),
        .up_wr_data (up_wr_data),
        .up_ack_vld (up_ack_vld),
        .up_rd_data (up_rd_data),
        .up_err     (up_err),
        .dn_req_vld (dn_req_vld),
        .dn_wr_en   (dn_wr_en),
        .dn_rd_en   (dn_rd_en),
        .dn_addr    (dn_addr),
        .dn_wr_data (dn_wr_data),
        .dn_ack_vld (dn_ack_vld),
        .dn_rd_data (dn_rd_data),
        .dn_err     (dn_err),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int id, input logic wr, input logic rd,
                           input logic [31:0] a, input logic [31:0] d);
        up_req_vld[id]          = 1'b1;
        up_wr_en[id]            = wr;
        up_rd_en[id]            = rd;
        up_addr[id*32 +: 32]    = a;
        up_wr_data[id*32 +: 32] = d;
    endtask

    // Downstream responder for one transaction. Cycle 0 is the current IDLE negedge.
    // dly<0 never acks; otherwise the ack is driven in WAIT cycle number dly (0-based).
    task automatic serve(input int dly, input logic [31:0] rdat, input logic derr,
                         output int req_c, output int ack_c, output logic [3:0] ack_v,
                         output logic [31:0] rd_o, output logic err_o, output logic [1:0] gid,
                         output logic [31:0] addr_o, output logic wr_o, output logic rd_en_o,
                         output logic busy_gap);
        logic done;
        done = 1'b0;
        req_c = -1; ack_c = -1; ack_v = '0; rd_o = '0; err_o = 1'b0; gid = '0;
        addr_o = '0; wr_o = 1'b0; rd_en_o = 1'b0; busy_gap = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            dn_ack_vld = 1'b0;
            if (dn_req_vld) begin
                req_c   = c;
                addr_o  = dn_addr;
                wr_o    = dn_wr_en;
                rd_en_o = dn_rd_en;
            end
            if (req_c >= 0 && dly >= 0 && c == req_c + 1 + dly) begin
                dn_ack_vld = 1'b1;
                dn_rd_data = rdat;
                dn_err     = derr;
            end
            if (c > 0 && !busy) busy_gap = 1'b1;
            if (up_ack_vld != 4'b0) begin
                ack_c  = c;
                ack_v  = up_ack_vld;
                rd_o   = up_rd_data;
                err_o  = up_err;
                gid    = grant_id;
                up_req_vld = up_req_vld & ~up_ack_vld;
                done   = 1'b1;
            end
            tick();
        end
        dn_ack_vld = 1'b0;
        $display("txn: grant=%0d req_cyc=%0d ack_cyc=%0d ack=%b rd=%h err=%0b",
                 gid, req_c, ack_c, ack_v, rd_o, err_o);
    endtask

    int          rc, ac;
    logic [3:0]  av, acc;
    logic [31:0] ro, ao;
    logic        eo, wo, reo, bg;
    logic [1:0]  gd;

    initial begin
        rst = 1'b1; soft_rst = 1'b0;
        up_req_vld = '0; up_wr_en = '0; up_rd_en = '0; up_addr = '0; up_wr_data = '0;
        dn_ack_vld = 1'b0; dn_rd_data = '0; dn_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_ack", up_ack_vld, 0);
        chk("rst_dnreq", dn_req_vld, 0);
        chk("rst_dnaddr", dn_addr, 0);

        // Single write, cycle by cycle; fields change after grant must not matter
        set_req(0, 1'b1, 1'b0, 32'h10, 32'hA5A5_0001);
        tick();
        $display("single write: cycle1 dn_req=%0b addr=%h", dn_req_vld, dn_addr);
        chk("wr_c1_dnreq", dn_req_vld, 1);
        chk("wr_c1_addr", dn_addr, 32'h10);
        chk("wr_c1_data", dn_wr_data, 32'hA5A5_0001);
        chk("wr_c1_wren", dn_wr_en, 1);
        chk("wr_c1_busy", busy, 1);
        up_addr[31:0] = 32'hFFFF_FFFF;
        up_wr_data[31:0] = 32'h0;
        tick();
        chk("wr_c2_dnreq", dn_req_vld, 0);
        chk("wr_c2_addr_held", dn_addr, 32'h10);
        chk("wr_c2_data_held", dn_wr_data, 32'hA5A5_0001);
        dn_ack_vld = 1'b1; dn_rd_data = 32'h5555_5555; dn_err = 1'b0;
        tick();
        dn_ack_vld = 1'b0;
        $display("single write: cycle3 ack=%b err=%0b rd=%h", up_ack_vld, up_err, up_rd_data);
        chk("wr_c3_ack", up_ack_vld, 4'b0001);
        chk("wr_c3_err", up_err, 0);
        chk("wr_c3_rd", up_rd_data, 0);
        up_req_vld[0] = 1'b0;
        tick();
        chk("wr_c4_idle", busy, 0);
        chk("wr_c4_ack", up_ack_vld, 0);

        // Reinit so round-robin starts from requester 0 again
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;

        // Round-robin with all four pending; req2 sees a downstream error,
        // req3 has wr and rd both set so it becomes a write with zero read data
        set_req(0, 1'b1, 1'b0, 32'h100, 32'h1000);
        set_req(1, 1'b0, 1'b1, 32'h101, 32'h1001);
        set_req(2, 1'b1, 1'b0, 32'h102, 32'h1002);
        set_req(3, 1'b1, 1'b1, 32'h103, 32'h1003);
        for (int k = 0; k < 4; k++) begin
            serve(0, 32'h1234_5678, (k == 2), rc, ac, av, ro, eo, gd, ao, wo, reo, bg);
            chk("rr_gid", gd, k);
            chk("rr_ack", av, 4'b0001 << k);
            chk("rr_addr", ao, 32'h100 + k);
            chk("rr_ackcyc", ac, 3);
            chk("rr_err", eo, (k == 2));
            chk("rr_rd", ro, (k == 1) ? 32'h1234_5678 : 32'h0);
            if (k == 3) begin
                chk("rr_both_wr", wo, 1);
                chk("rr_both_rd", reo, 0);
            end
        end

        // last_grant=1, then reqs 0 and 2 pending -> 2 before 0
        set_req(1, 1'b1, 1'b0, 32'h111, 32'h0);
        serve(0, 32'h0, 1'b0, rc, ac, av, ro, eo, gd, ao, wo, reo, bg);
        chk("rr1_gid", gd, 1);
        set_req(0, 1'b1, 1'b0, 32'h120, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h122, 32'h0);
        serve(0, 32'h0, 1'b0, rc, ac, av, ro, eo, gd, ao, wo, reo, bg);
        chk("rr20_first", gd, 2);
        serve(0, 32'h0, 1'b0, rc, ac, av, ro, eo, gd, ao, wo, reo, bg);
        chk("rr20_second", gd, 0);

        // Read with 5 wait states: ack driven in cycle 7, RESP in cycle 8
        set_req(2, 1'b0, 1'b1, 32'h200, 32'h0);
        serve(5, 32'hDEAD_BEEF, 1'b0, rc, ac, av, ro, eo, gd, ao, wo, reo, bg);
        chk("rdw_ack", av, 4'b0100);
        chk("rdw_data", ro, 32'hDEAD_BEEF);
        chk("rdw_err", eo, 0);
        chk("rdw_cyc", ac, 8);
        chk("rdw_busy", bg, 0);
        chk("rdw_rden", reo, 1);

        // Timeout: ISSUE in cycle 1, 8 WAIT cycles (2..9), RESP in cycle 10
        set_req(0, 1'b0, 1'b1, 32'h300, 32'h0);
        serve(-1, 32'h0, 1'b0, rc, ac, av, ro, eo, gd, ao, wo, reo, bg);
        chk("to_cyc", ac, 10);
        chk("to_ack", av, 4'b0001);
        chk("to_err", eo, 1);
        chk("to_rd", ro, 0);
        // late ack two cycles after RESP (cycle 12) must be ignored
        tick();
        dn_ack_vld = 1'b1;
        tick();
        dn_ack_vld = 1'b0;
        chk("late_ack", up_ack_vld, 0);
        chk("late_busy", busy, 0);
        tick();
        chk("late_ack2", up_ack_vld, 0);

        // Illegal command: no downstream request, error ack one cycle after IDLE
        set_req(1, 1'b0, 1'b0, 32'h400, 32'h0);
        serve(0, 32'h0, 1'b0, rc, ac, av, ro, eo, gd, ao, wo, reo, bg);
        chk("ill_nodn", rc, -1);
        chk("ill_cyc", ac, 1);
        chk("ill_ack", av, 4'b0010);
        chk("ill_err", eo, 1);
        chk("ill_rd", ro, 0);

        // soft_rst in WAIT (last_grant=1, req2 granted)
        set_req(2, 1'b1, 1'b0, 32'h500, 32'h55);
        tick();
        chk("sr_gid", grant_id, 2);
        tick();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        up_req_vld = '0;
        $display("soft_rst abort: busy=%0b gid=%0d dn_addr=%h", busy, grant_id, dn_addr);
        chk("sr_busy", busy, 0);
        chk("sr_gid0", grant_id, 0);
        chk("sr_dnaddr", dn_addr, 0);
        chk("sr_dnwr", dn_wr_en, 0);
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            acc = acc | up_ack_vld;
            tick();
        end
        chk("sr_noack", acc, 0);
        set_req(0, 1'b1, 1'b0, 32'h600, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h602, 32'h0);
        serve(0, 32'h0, 1'b0, rc, ac, av, ro, eo, gd, ao, wo, reo, bg);
        chk("sr_next_gid", gd, 0);
        up_req_vld[2] = 1'b0;

        // async rst in ISSUE (last_grant=0, req1 granted)
        set_req(1, 1'b1, 1'b0, 32'h700, 32'h0);
        tick();
        chk("ar_dnreq", dn_req_vld, 1);
        chk("ar_gid", grant_id, 1);
        #1 rst = 1'b1;
        #1;
        $display("async rst abort: busy=%0b dn_req=%0b gid=%0d", busy, dn_req_vld, grant_id);
        chk("ar_busy", busy, 0);
        chk("ar_dnreq0", dn_req_vld, 0);
        chk("ar_gid0", grant_id, 0);
        chk("ar_dnaddr", dn_addr, 0);
        #1 rst = 1'b0;
        up_req_vld = '0;
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acc = acc | up_ack_vld;
        end
        chk("ar_noack", acc, 0);
        set_req(0, 1'b1, 1'b0, 32'h800, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h802, 32'h0);
        serve(0, 32'h0, 1'b0, rc, ac, av, ro, eo, gd, ao, wo, reo, bg);
        chk("ar_next_gid", gd, 0);
        up_req_vld = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
